mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage between ex_stage and writeback.
- Consumes EX outputs: result as the ALU value or the effective address, destination register, mem flags and CSR fields.
- Performs aligned loads and stores over a single-outstanding request/ack data bus, and registers the writeback bundle.
- Raises mem_stall upstream while an access is pending, and reports misalignment and bus-fault exceptions.

Parameters:
- XLEN, 32, datapath and address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- result_i  in  XLEN  ALU result / effective address
- store_data_i  in  XLEN  rs2 value for stores
- waddr_i  in  5  destination register
- we_i  in  1  register write enable
- mem_flags_i  in  6  [1:0] size (00 B, 01 H, 10 W, 11 illegal→W); [2] unsigned load; [3] load; [4] store; [5] ignored
- mem_ex_sel_i  in  1  1 = writeback takes load data, 0 = takes result_i
- csr_op_i  in  3  pass-through
- csr_imm_op_i  in  1  pass-through
- exc_addr_if_i  in  1  pass-through
- dmem_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  out  XLEN  store data, lane-replicated
- dmem_sel_o  out  4  byte lane enables
- dmem_we_o  out  1  write strobe
- dmem_cyc_o  out  1  request valid
- dmem_rdata_i  in  XLEN  read data
- dmem_ack_i  in  1  access complete
- dmem_err_i  in  1  access faulted (qualified by ack)
- mem_stall_o  out  1  hold EX/ID/IF
- wb_result_o  out  XLEN  writeback value
- wb_waddr_o  out  5  writeback register
- wb_we_o  out  1  writeback enable
- wb_csr_op_o  out  3  pass-through
- wb_csr_imm_op_o  out  1  pass-through
- wb_exc_addr_if_o  out  1  pass-through
- exc_load_misaligned_o  out  1  one-cycle pulse
- exc_store_misaligned_o  out  1  one-cycle pulse
- exc_load_fault_o  out  1  one-cycle pulse
- exc_store_fault_o  out  1  one-cycle pulse
- exc_badaddr_o  out  XLEN  faulting address, valid with any exc pulse

Behaviour:
- Reset: all wb_*, exc_*, dmem_* outputs go to 0 immediately. State = IDLE.
- Op classification:
  - memop = load | store. Store wins if both are set.
  - Misaligned when H with addr[0]=1, or W with addr[1:0]≠0.
- FSM states: IDLE, BUSY.
- IDLE, non-memop: next edge captures wb_result=result_i, wb_waddr, wb_we = we_i & (waddr_i≠0), and the pass-throughs. mem_stall=0. Latency 1.
- IDLE, misaligned memop:
  - No bus cycle; mem_stall=0.
  - Next edge: wb_we=0, matching exc_*_misaligned=1, exc_badaddr=result_i.
- IDLE, aligned memop:
  - mem_stall=1 combinationally.
  - Next edge registers dmem_addr/wdata/sel/we, sets dmem_cyc=1, and moves to BUSY.
  - wb_we=0 (bubble) on that edge.
- Lane rules:
  - B: sel = 1<<addr[1:0], wdata = {4{d[7:0]}}.
  - H: sel = addr[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - W: sel = 1111.
- BUSY, ack=0: dmem_* held stable, mem_stall=1, wb_we=0.
- BUSY, ack=1, err=0:
  - mem_stall=0 in the same cycle.
  - Next edge: cyc=0, state→IDLE.
  - Load: rdata shifted right by addr[1:0]*8, then sign- or zero-extended per size/unsigned. Writeback takes load data when mem_ex_sel=1, else result_i; wb_we = we_i & waddr≠0.
  - Store: wb_we=0.
- BUSY, ack=1, err=1:
  - Same completion timing as a normal ack.
  - wb_we=0, exc_load_fault or exc_store_fault pulses, exc_badaddr = the access address.
- Minimum memop latency is 2 cycles. The bus must hold dmem_rdata valid only in the ack cycle.
- Inputs are sampled only when mem_stall=0, or in the IDLE→BUSY transition. Upstream must hold its inputs while mem_stall=1.
- Asynchronous reset during BUSY drops dmem_cyc immediately and abandons the access. A late ack after reset is ignored.
- At most one exc_* output pulses per instruction.

Test Plan:
- ALU op: result_i=0x1234, waddr=5, we=1, flags=0 → next cycle wb_result=0x1234, wb_we=1, mem_stall never high.
- LB at 0x103, rdata=0x80FFFFFF, ack after 1 wait cycle → sel=1000, wb_result=0xFFFFFF80. Repeating as LBU → 0x00000080. Stall held high for 2 cycles.
- SH of 0xA5A55A5A at 0x202 → dmem_addr=0x200, sel=1100, wdata=0x5A5A5A5A, we=1, wb_we=0. Same at 0x201 → no cyc, exc_store_misaligned pulse, exc_badaddr=0x201.
- LW at 0x40, ack delayed 3 cycles → dmem_* stable throughout, mem_stall=1 until the ack cycle, then wb_result=rdata.
- LW with ack+err → exc_load_fault pulse, exc_badaddr=0x40, wb_we=0, next ALU op proceeds normally.
- Assert rst mid-BUSY → dmem_cyc=0 immediately, all outputs 0, FSM IDLE; a later ack produces no writeback.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: aligned loads/stores over a single-outstanding bus, registered writeback
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      waddr_i,
  input  logic            we_i,
  input  logic [5:0]      mem_flags_i,
  input  logic            mem_ex_sel_i,
  input  logic [2:0]      csr_op_i,
  input  logic            csr_imm_op_i,
  input  logic            exc_addr_if_i,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_sel_o,
  output logic            dmem_we_o,
  output logic            dmem_cyc_o,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_ack_i,
  input  logic            dmem_err_i,
  output logic            mem_stall_o,
  output logic [XLEN-1:0] wb_result_o,
  output logic [4:0]      wb_waddr_o,
  output logic            wb_we_o,
  output logic [2:0]      wb_csr_op_o,
  output logic            wb_csr_imm_op_o,
  output logic            wb_exc_addr_if_o,
  output logic            exc_load_misaligned_o,
  output logic            exc_store_misaligned_o,
  output logic            exc_load_fault_o,
  output logic            exc_store_fault_o,
  output logic [XLEN-1:0] exc_badaddr_o
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  // Instruction context captured on IDLE->BUSY, used when the ack arrives
  logic [XLEN-1:0] addr_q;
  logic [1:0]      size_q;
  logic            uns_q, store_q, ex_sel_q, we_q, csr_imm_q, exc_if_q;
  logic [4:0]      waddr_q;
  logic [2:0]      csr_op_q;

  logic [1:0]      size;
  logic            is_store, memop, misaligned;
  logic [3:0]      sel_n;
  logic [XLEN-1:0] wdata_n, shifted, load_data;

  assign size       = (mem_flags_i[1:0] == 2'b11) ? 2'b10 : mem_flags_i[1:0];
  assign is_store   = mem_flags_i[4];
  assign memop      = mem_flags_i[3] | mem_flags_i[4];
  assign misaligned = ((size == 2'b01) && result_i[0]) || ((size == 2'b10) && (result_i[1:0] != 2'b00));
  assign mem_stall_o = (state == IDLE) ? (memop & ~misaligned) : ~dmem_ack_i;

  always_comb begin
    sel_n   = 4'b1111;
    wdata_n = store_data_i;
    case (size)
      2'b00: begin
        sel_n   = 4'b0001 << result_i[1:0];
        wdata_n = {(XLEN/8){store_data_i[7:0]}};
      end
      2'b01: begin
        sel_n   = result_i[1] ? 4'b1100 : 4'b0011;
        wdata_n = {(XLEN/16){store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    load_data = shifted;
    case (size_q)
      2'b00:   load_data = {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dmem_addr_o <= '0; dmem_wdata_o <= '0; dmem_sel_o <= '0; dmem_we_o <= 1'b0; dmem_cyc_o <= 1'b0;
      wb_result_o <= '0; wb_waddr_o <= '0; wb_we_o <= 1'b0;
      wb_csr_op_o <= '0; wb_csr_imm_op_o <= 1'b0; wb_exc_addr_if_o <= 1'b0;
      exc_load_misaligned_o <= 1'b0; exc_store_misaligned_o <= 1'b0;
      exc_load_fault_o <= 1'b0; exc_store_fault_o <= 1'b0; exc_badaddr_o <= '0;
      addr_q <= '0; size_q <= '0; uns_q <= 1'b0; store_q <= 1'b0; ex_sel_q <= 1'b0;
      we_q <= 1'b0; waddr_q <= '0; csr_op_q <= '0; csr_imm_q <= 1'b0; exc_if_q <= 1'b0;
    end else begin
      exc_load_misaligned_o  <= 1'b0;
      exc_store_misaligned_o <= 1'b0;
      exc_load_fault_o       <= 1'b0;
      exc_store_fault_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (!memop) begin
            wb_result_o      <= result_i;
            wb_waddr_o       <= waddr_i;
            wb_we_o          <= we_i & (waddr_i != 5'd0);
            wb_csr_op_o      <= csr_op_i;
            wb_csr_imm_op_o  <= csr_imm_op_i;
            wb_exc_addr_if_o <= exc_addr_if_i;
          end else if (misaligned) begin
            wb_we_o                <= 1'b0;
            exc_store_misaligned_o <= is_store;
            exc_load_misaligned_o  <= ~is_store;
            exc_badaddr_o          <= result_i;
          end else begin
            wb_we_o      <= 1'b0;
            dmem_addr_o  <= {result_i[XLEN-1:2], 2'b00};
            dmem_wdata_o <= wdata_n;
            dmem_sel_o   <= sel_n;
            dmem_we_o    <= is_store;
            dmem_cyc_o   <= 1'b1;
            addr_q <= result_i; size_q <= size; uns_q <= mem_flags_i[2]; store_q <= is_store;
            ex_sel_q <= mem_ex_sel_i; we_q <= we_i; waddr_q <= waddr_i;
            csr_op_q <= csr_op_i; csr_imm_q <= csr_imm_op_i; exc_if_q <= exc_addr_if_i;
            state <= BUSY;
          end
        end
        BUSY: begin
          wb_we_o <= 1'b0;
          if (dmem_ack_i) begin
            dmem_cyc_o       <= 1'b0;
            dmem_we_o        <= 1'b0;
            state            <= IDLE;
            wb_waddr_o       <= waddr_q;
            wb_csr_op_o      <= csr_op_q;
            wb_csr_imm_op_o  <= csr_imm_q;
            wb_exc_addr_if_o <= exc_if_q;
            if (dmem_err_i) begin
              exc_store_fault_o <= store_q;
              exc_load_fault_o  <= ~store_q;
              exc_badaddr_o     <= addr_q;
            end else if (!store_q) begin
              wb_result_o <= ex_sel_q ? load_data : addr_q;
              wb_we_o     <= we_q & (waddr_q != 5'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk, rst;
  logic [31:0] result_i, store_data_i, dmem_rdata_i;
  logic [4:0]  waddr_i;
  logic        we_i, mem_ex_sel_i, csr_imm_op_i, exc_addr_if_i, dmem_ack_i, dmem_err_i;
  logic [5:0]  mem_flags_i;
  logic [2:0]  csr_op_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_result_o, exc_badaddr_o;
  logic [3:0]  dmem_sel_o;
  logic        dmem_we_o, dmem_cyc_o, mem_stall_o, wb_we_o, wb_csr_imm_op_o, wb_exc_addr_if_o;
  logic [4:0]  wb_waddr_o;
  logic [2:0]  wb_csr_op_o;
  logic        exc_load_misaligned_o, exc_store_misaligned_o, exc_load_fault_o, exc_store_fault_o;

  int errors = 0;
  int checks = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .result_i(result_i), .store_data_i(store_data_i), .waddr_i(waddr_i),
    .we_i(we_i), .mem_flags_i(mem_flags_i), .mem_ex_sel_i(mem_ex_sel_i), .csr_op_i(csr_op_i),
    .csr_imm_op_i(csr_imm_op_i), .exc_addr_if_i(exc_addr_if_i), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_sel_o(dmem_sel_o), .dmem_we_o(dmem_we_o),
    .dmem_cyc_o(dmem_cyc_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .dmem_err_i(dmem_err_i), .mem_stall_o(mem_stall_o), .wb_result_o(wb_result_o),
    .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o), .wb_csr_op_o(wb_csr_op_o),
    .wb_csr_imm_op_o(wb_csr_imm_op_o), .wb_exc_addr_if_o(wb_exc_addr_if_o),
    .exc_load_misaligned_o(exc_load_misaligned_o), .exc_store_misaligned_o(exc_store_misaligned_o),
    .exc_load_fault_o(exc_load_fault_o), .exc_store_fault_o(exc_store_fault_o),
    .exc_badaddr_o(exc_badaddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [31:0] r, input logic [31:0] sd, input logic [4:0] wa,
                        input logic w, input logic [5:0] f, input logic es);
    result_i = r; store_data_i = sd; waddr_i = wa; we_i = w; mem_flags_i = f; mem_ex_sel_i = es;
  endtask

  task automatic idle_in();
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 6'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_in(); csr_op_i = 3'b0; csr_imm_op_i = 1'b0; exc_addr_if_i = 1'b0;
    dmem_rdata_i = 32'h0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (dmem_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", dmem_cyc_o); end
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b expected 0", wb_we_o); end
    checks++; if (wb_result_o !== 32'h0) begin errors++; $display("FAIL reset_wb_result: got %h expected 0", wb_result_o); end
    checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall_o); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    set_in(32'h1234, 32'h0, 5'd5, 1'b1, 6'b100000, 1'b0); csr_op_i = 3'b101; #1;
    checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", mem_stall_o); end
    @(negedge clk);
    checks++; if (wb_result_o !== 32'h1234) begin errors++; $display("FAIL alu_result: got %h expected 00001234", wb_result_o); end
    checks++; if (wb_we_o !== 1'b1) begin errors++; $display("FAIL alu_we: got %b expected 1", wb_we_o); end
    checks++; if (wb_waddr_o !== 5'd5) begin errors++; $display("FAIL alu_waddr: got %0d expected 5", wb_waddr_o); end
    checks++; if (wb_csr_op_o !== 3'b101) begin errors++; $display("FAIL alu_csr_op: got %b expected 101", wb_csr_op_o); end
    set_in(32'h77, 32'h0, 5'd0, 1'b1, 6'b0, 1'b0); csr_op_i = 3'b0;
    @(negedge clk);
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL alu_x0_we: got %b expected 0", wb_we_o); end
    idle_in();
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] exp);
    @(negedge clk);
    set_in(32'h103, 32'h0, 5'd7, 1'b1, {2'b00, 1'b1, uns, 2'b00}, 1'b1); #1;
    checks++; if (mem_stall_o !== 1'b1) begin errors++; $display("FAIL lb_stall0: got %b expected 1", mem_stall_o); end
    @(negedge clk);
    checks++; if (dmem_cyc_o !== 1'b1) begin errors++; $display("FAIL lb_cyc: got %b expected 1", dmem_cyc_o); end
    checks++; if (dmem_sel_o !== 4'b1000) begin errors++; $display("FAIL lb_sel: got %b expected 1000", dmem_sel_o); end
    checks++; if (dmem_addr_o !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h expected 00000100", dmem_addr_o); end
    checks++; if (mem_stall_o !== 1'b1) begin errors++; $display("FAIL lb_stall1: got %b expected 1", mem_stall_o); end
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL lb_bubble: got %b expected 0", wb_we_o); end
    @(negedge clk);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FFFFFF; #1;
    checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL lb_stall_ack: got %b expected 0", mem_stall_o); end
    @(negedge clk);
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0; idle_in();
    checks++; if (wb_result_o !== exp) begin errors++; $display("FAIL lb_result uns=%b: got %h expected %h", uns, wb_result_o, exp); end
    checks++; if (wb_we_o !== 1'b1) begin errors++; $display("FAIL lb_we: got %b expected 1", wb_we_o); end
    checks++; if (dmem_cyc_o !== 1'b0) begin errors++; $display("FAIL lb_cyc_end: got %b expected 0", dmem_cyc_o); end
  endtask

  task automatic test_store_half();
    @(negedge clk);
    set_in(32'h202, 32'hA5A55A5A, 5'd0, 1'b0, 6'b010001, 1'b0);
    @(negedge clk);
    checks++; if (dmem_addr_o !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h expected 00000200", dmem_addr_o); end
    checks++; if (dmem_sel_o !== 4'b1100) begin errors++; $display("FAIL sh_sel: got %b expected 1100", dmem_sel_o); end
    checks++; if (dmem_wdata_o !== 32'h5A5A5A5A) begin errors++; $display("FAIL sh_wdata: got %h expected 5a5a5a5a", dmem_wdata_o); end
    checks++; if (dmem_we_o !== 1'b1) begin errors++; $display("FAIL sh_we: got %b expected 1", dmem_we_o); end
    dmem_ack_i = 1'b1;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL sh_wb_we: got %b expected 0", wb_we_o); end
    checks++; if (dmem_cyc_o !== 1'b0) begin errors++; $display("FAIL sh_cyc_end: got %b expected 0", dmem_cyc_o); end
    set_in(32'h201, 32'hA5A55A5A, 5'd0, 1'b0, 6'b010001, 1'b0); #1;
    checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL sh_mis_stall: got %b expected 0", mem_stall_o); end
    @(negedge clk);
    idle_in();
    checks++; if (dmem_cyc_o !== 1'b0) begin errors++; $display("FAIL sh_mis_cyc: got %b expected 0", dmem_cyc_o); end
    checks++; if (exc_store_misaligned_o !== 1'b1) begin errors++; $display("FAIL sh_mis_exc: got %b expected 1", exc_store_misaligned_o); end
    checks++; if (exc_load_misaligned_o !== 1'b0) begin errors++; $display("FAIL sh_mis_lexc: got %b expected 0", exc_load_misaligned_o); end
    checks++; if (exc_badaddr_o !== 32'h201) begin errors++; $display("FAIL sh_mis_badaddr: got %h expected 00000201", exc_badaddr_o); end
    @(negedge clk);
    checks++; if (exc_store_misaligned_o !== 1'b0) begin errors++; $display("FAIL sh_mis_pulse: got %b expected 0", exc_store_misaligned_o); end
  endtask

  task automatic test_load_word_wait();
    @(negedge clk);
    set_in(32'h40, 32'h0, 5'd9, 1'b1, 6'b001010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mem_stall_o !== 1'b1) begin errors++; $display("FAIL lw_stall[%0d]: got %b expected 1", i, mem_stall_o); end
      checks++; if (dmem_addr_o !== 32'h40 || dmem_sel_o !== 4'b1111 || dmem_cyc_o !== 1'b1 || dmem_we_o !== 1'b0) begin
        errors++; $display("FAIL lw_hold[%0d]: got addr=%h sel=%b cyc=%b we=%b expected 00000040 1111 1 0", i, dmem_addr_o, dmem_sel_o, dmem_cyc_o, dmem_we_o);
      end
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF; #1;
    checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL lw_stall_ack: got %b expected 0", mem_stall_o); end
    @(negedge clk);
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0; idle_in();
    checks++; if (wb_result_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_result: got %h expected deadbeef", wb_result_o); end
    checks++; if (wb_waddr_o !== 5'd9 || wb_we_o !== 1'b1) begin errors++; $display("FAIL lw_wb: got waddr=%0d we=%b expected 9 1", wb_waddr_o, wb_we_o); end
  endtask

  task automatic test_load_fault();
    @(negedge clk);
    set_in(32'h40, 32'h0, 5'd9, 1'b1, 6'b001010, 1'b1);
    @(negedge clk);
    dmem_ack_i = 1'b1; dmem_err_i = 1'b1; dmem_rdata_i = 32'h11111111;
    @(negedge clk);
    dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = 32'h0;
    checks++; if (exc_load_fault_o !== 1'b1) begin errors++; $display("FAIL lf_exc: got %b expected 1", exc_load_fault_o); end
    checks++; if (exc_store_fault_o !== 1'b0) begin errors++; $display("FAIL lf_sexc: got %b expected 0", exc_store_fault_o); end
    checks++; if (exc_badaddr_o !== 32'h40) begin errors++; $display("FAIL lf_badaddr: got %h expected 00000040", exc_badaddr_o); end
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL lf_wb_we: got %b expected 0", wb_we_o); end
    set_in(32'h55, 32'h0, 5'd3, 1'b1, 6'b0, 1'b0);
    @(negedge clk);
    idle_in();
    checks++; if (wb_result_o !== 32'h55 || wb_we_o !== 1'b1) begin errors++; $display("FAIL lf_next_alu: got %h we=%b expected 00000055 1", wb_result_o, wb_we_o); end
    checks++; if (exc_load_fault_o !== 1'b0) begin errors++; $display("FAIL lf_pulse: got %b expected 0", exc_load_fault_o); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    set_in(32'h80, 32'h0, 5'd4, 1'b1, 6'b001010, 1'b1);
    @(negedge clk);
    checks++; if (dmem_cyc_o !== 1'b1) begin errors++; $display("FAIL rb_cyc_pre: got %b expected 1", dmem_cyc_o); end
    rst = 1'b1; idle_in(); #1;
    checks++; if (dmem_cyc_o !== 1'b0) begin errors++; $display("FAIL rb_cyc: got %b expected 0", dmem_cyc_o); end
    checks++; if (dmem_sel_o !== 4'b0 || dmem_addr_o !== 32'h0) begin errors++; $display("FAIL rb_dmem: got sel=%b addr=%h expected 0 0", dmem_sel_o, dmem_addr_o); end
    checks++; if (wb_we_o !== 1'b0 || wb_result_o !== 32'h0) begin errors++; $display("FAIL rb_wb: got we=%b res=%h expected 0 0", wb_we_o, wb_result_o); end
    checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL rb_stall: got %b expected 0", mem_stall_o); end
    @(negedge clk);
    rst = 1'b0; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12345678;
    @(negedge clk);
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    checks++; if (wb_we_o !== 1'b0 || wb_result_o !== 32'h0) begin errors++; $display("FAIL rb_late_ack: got we=%b res=%h expected 0 0", wb_we_o, wb_result_o); end
    checks++; if (dmem_cyc_o !== 1'b0) begin errors++; $display("FAIL rb_cyc_post: got %b expected 0", dmem_cyc_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte(1'b0, 32'hFFFFFF80);
    test_load_byte(1'b1, 32'h00000080);
    test_store_half();
    test_load_word_wait();
    test_load_fault();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
